// File: rtl/dna_pattern_scanner.sv
// dna_pattern_scanner: accepts nucleotide button presses (A, C, G, T), keeps a
// PAT_LEN-deep history and pulses match whenever the latest PAT_LEN symbols equal
// the loaded target pattern. It also tracks sticky mutant/super_mutant flags and a
// saturating match counter.
//
// Optional feature: define DNA_DEBOUNCE_EN to insert a DEB_CYCLES stable-level
// filter after each button's two-flop synchronizer.
//
// Symbol encoding: A=00, C=01, G=10, T=11. Nucleotide 0 (oldest) sits in bits [1:0].
module dna_pattern_scanner #(
    parameter int unsigned PAT_LEN      = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned SUPER_THRESH = 3,
    parameter int unsigned DEB_CYCLES   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 A,
    input  logic                 G,
    input  logic                 C,
    input  logic                 T,
    input  logic                 pat_load,
    input  logic [2*PAT_LEN-1:0] pat_data,
    output logic                 match,
    output logic                 mutant,
    output logic                 super_mutant,
    output logic [CNT_W-1:0]     match_count,
    output logic [3:0]           fill,
    output logic                 sym_err
);

    localparam int unsigned HW = 2 * PAT_LEN;

    typedef enum logic [1:0] {
        StEmpty,
        StFilling,
        StArmed
    } state_e;

    // Button vector indexed by symbol code: bit 0 = A, 1 = C, 2 = G, 3 = T.
    logic [3:0] raw;
    assign raw = {T, G, C, A};

    logic [3:0] sync1_q, sync2_q;
    logic [3:0] cond;
    logic [3:0] prev_q;
    logic [3:0] rise;

    // Two-flop synchronizer. The flops reset to "pressed" so that a button held
    // through reset never looks like a fresh rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef DNA_DEBOUNCE_EN
    localparam int unsigned DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [3:0]     deb_q;
    logic [DCW-1:0] deb_cnt_q [4];

    // Stable-level filter: the output follows the synchronized level only after it
    // has differed from the current output for DEB_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q <= '1;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (deb_cnt_q[i] == DCW'(DEB_CYCLES - 1)) begin
                        deb_q[i]     <= sync2_q[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + DCW'(1);
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign cond = deb_q;
`else
    assign cond = sync2_q;
`endif

    // Previous conditioned level for rising-edge detection. Reset high for the
    // same reason as the synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '1;
        end else begin
            prev_q <= cond;
        end
    end

    assign rise = cond & ~prev_q;

    logic       one_rise;
    logic [1:0] sym;
    logic       accept;
    logic       reject;

    // Decode a single rising edge into a symbol; acceptance also needs every
    // other button to be released.
    always_comb begin
        one_rise = 1'b0;
        sym      = 2'b00;
        unique case (rise)
            4'b0001: begin one_rise = 1'b1; sym = 2'b00; end
            4'b0010: begin one_rise = 1'b1; sym = 2'b01; end
            4'b0100: begin one_rise = 1'b1; sym = 2'b10; end
            4'b1000: begin one_rise = 1'b1; sym = 2'b11; end
            default: begin one_rise = 1'b0; sym = 2'b00; end
        endcase
        accept = one_rise && (cond == rise);
        reject = (|rise) && !accept;
    end

    state_e           state_q, state_d;
    logic [HW-1:0]    pat_q, pat_d;
    logic [HW-1:0]    hist_q, hist_d;
    logic [3:0]       fill_q, fill_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             match_q, match_d;
    logic             mutant_q, mutant_d;
    logic             super_q, super_d;
    logic             sym_err_q, sym_err_d;

    // Sequencer next state: pattern load wins over any button activity, otherwise
    // an accepted symbol shifts in, advances fill and is compared once armed.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        count_d   = count_q;
        match_d   = 1'b0;
        mutant_d  = mutant_q;
        super_d   = super_q;
        sym_err_d = 1'b0;

        if (pat_load) begin
            pat_d    = pat_data;
            hist_d   = '0;
            fill_d   = '0;
            count_d  = '0;
            mutant_d = 1'b0;
            super_d  = 1'b0;
            state_d  = StEmpty;
        end else begin
            sym_err_d = reject;
            if (accept) begin
                hist_d = {sym, hist_q[HW-1:2]};
                unique case (state_q)
                    StEmpty: begin
                        fill_d  = 4'd1;
                        state_d = StFilling;
                    end
                    StFilling: begin
                        fill_d  = fill_q + 4'd1;
                        state_d = (fill_d == 4'(PAT_LEN)) ? StArmed : StFilling;
                    end
                    StArmed: begin
                        fill_d  = fill_q;
                        state_d = StArmed;
                    end
                    default: begin
                        fill_d  = '0;
                        state_d = StEmpty;
                    end
                endcase

                if (state_d == StArmed && hist_d == pat_q) begin
                    match_d  = 1'b1;
                    mutant_d = 1'b1;
                    if (count_q != '1) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (count_d >= CNT_W'(SUPER_THRESH)) begin
                        super_d = 1'b1;
                    end
                end
            end
        end
    end

    // State register; reset clears everything including the pattern (all A).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StEmpty;
            pat_q     <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            match_q   <= 1'b0;
            mutant_q  <= 1'b0;
            super_q   <= 1'b0;
            sym_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
            match_q   <= match_d;
            mutant_q  <= mutant_d;
            super_q   <= super_d;
            sym_err_q <= sym_err_d;
        end
    end

    assign match        = match_q;
    assign mutant       = mutant_q;
    assign super_mutant = super_q;
    assign match_count  = count_q;
    assign fill         = fill_q;
    assign sym_err      = sym_err_q;

endmodule

// File: tb/tb_dna_pattern_scanner.sv
// Bench for dna_pattern_scanner: a queue-based reference model pushes the expected
// outcome of every press; each test task pops and compares after the acceptance
// latency. A second instance (PAT_LEN=2, CNT_W=2) covers counter saturation.
module tb_dna_pattern_scanner;

    localparam int unsigned PAT_LEN = 4;
    localparam int unsigned SUPER   = 3;
    localparam int unsigned DEB     = 4;
`ifdef DNA_DEBOUNCE_EN
    localparam int LAT = 2 + DEB + 1;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn = '0;       // bit 0 = A, 1 = C, 2 = G, 3 = T
    logic       pat_load = 1'b0;
    logic [7:0] pat_data = '0;
    logic       match, mutant, super_mutant, sym_err;
    logic [7:0] match_count;
    logic [3:0] fill;

    logic [3:0] sat_btn = '0;
    logic       sat_load = 1'b0;
    logic [3:0] sat_pat = '0;
    logic       sat_match, sat_mutant, sat_super, sat_err;
    logic [1:0] sat_count;
    logic [3:0] sat_fill;

    always #5 clk = ~clk;

    dna_pattern_scanner #(
        .PAT_LEN(PAT_LEN), .CNT_W(8), .SUPER_THRESH(SUPER), .DEB_CYCLES(DEB)
    ) u_dut (
        .clk(clk), .reset(reset),
        .A(btn[0]), .G(btn[2]), .C(btn[1]), .T(btn[3]),
        .pat_load(pat_load), .pat_data(pat_data),
        .match(match), .mutant(mutant), .super_mutant(super_mutant),
        .match_count(match_count), .fill(fill), .sym_err(sym_err)
    );

    dna_pattern_scanner #(
        .PAT_LEN(2), .CNT_W(2), .SUPER_THRESH(3), .DEB_CYCLES(DEB)
    ) u_sat (
        .clk(clk), .reset(reset),
        .A(sat_btn[0]), .G(sat_btn[2]), .C(sat_btn[1]), .T(sat_btn[3]),
        .pat_load(sat_load), .pat_data(sat_pat),
        .match(sat_match), .mutant(sat_mutant), .super_mutant(sat_super),
        .match_count(sat_count), .fill(sat_fill), .sym_err(sat_err)
    );

    typedef struct {
        logic       m;
        logic [3:0] f;
        logic [7:0] c;
        logic       mu;
        logic       su;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] m_hist[$];
    logic [1:0] m_pat[PAT_LEN];
    int         m_count;
    logic       m_mut, m_sup;
    int         n_cmp = 0;
    int         n_fail = 0;

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < PAT_LEN; i++) m_pat[i] = 2'b00;
        m_count = 0;
        m_mut   = 1'b0;
        m_sup   = 1'b0;
        sb.delete();
    endtask

    task automatic model_load(input logic [7:0] p);
        m_hist.delete();
        for (int i = 0; i < PAT_LEN; i++) m_pat[i] = p[2*i +: 2];
        m_count = 0;
        m_mut   = 1'b0;
        m_sup   = 1'b0;
    endtask

    task automatic model_accept(input logic [1:0] s);
        exp_t e;
        bit   hit;
        m_hist.push_back(s);
        if (m_hist.size() > PAT_LEN) m_hist.delete(0);
        hit = (m_hist.size() == PAT_LEN);
        for (int i = 0; i < m_hist.size(); i++) if (m_hist[i] != m_pat[i]) hit = 0;
        if (hit) begin
            if (m_count < 255) m_count++;
            m_mut = 1'b1;
            if (m_count >= SUPER) m_sup = 1'b1;
        end
        e.m  = hit;
        e.f  = 4'(m_hist.size());
        e.c  = 8'(m_count);
        e.mu = m_mut;
        e.su = m_sup;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] pack4(input logic [1:0] s0, input logic [1:0] s1,
                                         input logic [1:0] s2, input logic [1:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    // Press one button, push the expected outcome, wait until the accepting edge.
    task automatic push_press(input logic [1:0] s);
        @(negedge clk);
        btn[s] = 1'b1;
        model_accept(s);
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        @(negedge clk);
        btn = '0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic load_pattern(input logic [7:0] p);
        @(negedge clk);
        pat_load = 1'b1;
        pat_data = p;
        model_load(p);
        @(negedge clk);
        pat_load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        btn = '0;
        sat_btn = '0;
        pat_load = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        @(negedge clk);
        reset = 1'b1;
        btn = '0;
        @(posedge clk);
        #1;
        n_cmp++; if (match !== 1'b0) begin n_fail++; $display("FAIL rst_match got %b want 0", match); end
        n_cmp++; if (mutant !== 1'b0) begin n_fail++; $display("FAIL rst_mutant got %b want 0", mutant); end
        n_cmp++; if (super_mutant !== 1'b0) begin n_fail++; $display("FAIL rst_super got %b want 0", super_mutant); end
        n_cmp++; if (match_count !== 8'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", match_count); end
        n_cmp++; if (fill !== 4'd0) begin n_fail++; $display("FAIL rst_fill got %0d want 0", fill); end
        n_cmp++; if (sym_err !== 1'b0) begin n_fail++; $display("FAIL rst_symerr got %b want 0", sym_err); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (LAT + 2) @(negedge clk);
        // Reset pattern is all A: four A presses must match.
        for (int i = 0; i < 4; i++) begin
            push_press(2'b00);
            e = sb.pop_front();
            n_cmp++; if (match !== e.m) begin n_fail++; $display("FAIL rstpat_match[%0d] got %b want %b", i, match, e.m); end
            n_cmp++; if (fill !== e.f) begin n_fail++; $display("FAIL rstpat_fill[%0d] got %0d want %0d", i, fill, e.f); end
            release_all();
        end
    endtask

    task automatic test_reset_hold();
        @(negedge clk);
        btn[0] = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (LAT + 8) @(negedge clk);
        n_cmp++; if (fill !== 4'd0) begin n_fail++; $display("FAIL hold_thru_reset_fill got %0d want 0", fill); end
        release_all();
    endtask

    task automatic test_single_match();
        exp_t       e;
        logic [1:0] seq[4];
        seq = '{2'b10, 2'b00, 2'b11, 2'b01};  // G A T C
        load_pattern(pack4(seq[0], seq[1], seq[2], seq[3]));
        for (int i = 0; i < 4; i++) begin
            push_press(seq[i]);
            e = sb.pop_front();
            n_cmp++; if (match !== e.m) begin n_fail++; $display("FAIL gatc_match[%0d] got %b want %b", i, match, e.m); end
            n_cmp++; if (fill !== e.f) begin n_fail++; $display("FAIL gatc_fill[%0d] got %0d want %0d", i, fill, e.f); end
            n_cmp++; if (match_count !== e.c) begin n_fail++; $display("FAIL gatc_count[%0d] got %0d want %0d", i, match_count, e.c); end
            n_cmp++; if (mutant !== e.mu) begin n_fail++; $display("FAIL gatc_mutant[%0d] got %b want %b", i, mutant, e.mu); end
            @(posedge clk);
            #1;
            n_cmp++; if (match !== 1'b0) begin n_fail++; $display("FAIL gatc_pulse[%0d] got %b want 0", i, match); end
            release_all();
        end
    endtask

    task automatic test_overlap_super();
        exp_t e;
        load_pattern(8'h00);
        for (int i = 0; i < 6; i++) begin
            push_press(2'b00);
            e = sb.pop_front();
            n_cmp++; if (match !== e.m) begin n_fail++; $display("FAIL aaaa_match[%0d] got %b want %b", i, match, e.m); end
            n_cmp++; if (match_count !== e.c) begin n_fail++; $display("FAIL aaaa_count[%0d] got %0d want %0d", i, match_count, e.c); end
            n_cmp++; if (super_mutant !== e.su) begin n_fail++; $display("FAIL aaaa_super[%0d] got %b want %b", i, super_mutant, e.su); end
            release_all();
        end
    endtask

    task automatic test_pat_load_and_reset();
        exp_t       e;
        logic [7:0] p;
        int         hits;
        p = pack4(2'b01, 2'b10, 2'b11, 2'b00);  // C G T A
        load_pattern(p);
        #1;
        n_cmp++; if (match_count !== 8'd0) begin n_fail++; $display("FAIL load_count got %0d want 0", match_count); end
        n_cmp++; if (mutant !== 1'b0) begin n_fail++; $display("FAIL load_mutant got %b want 0", mutant); end
        n_cmp++; if (super_mutant !== 1'b0) begin n_fail++; $display("FAIL load_super got %b want 0", super_mutant); end
        n_cmp++; if (fill !== 4'd0) begin n_fail++; $display("FAIL load_fill got %0d want 0", fill); end
        for (int i = 0; i < 3; i++) begin
            push_press(p[2*i +: 2]);
            e = sb.pop_front();
            n_cmp++; if (fill !== e.f) begin n_fail++; $display("FAIL partial_fill[%0d] got %0d want %0d", i, fill, e.f); end
            release_all();
        end
        do_reset();
        n_cmp++; if (fill !== 4'd0) begin n_fail++; $display("FAIL midreset_fill got %0d want 0", fill); end
        load_pattern(p);
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            push_press(p[2*i +: 2]);
            e = sb.pop_front();
            if (match === 1'b1) hits++;
            n_cmp++; if (match !== e.m) begin n_fail++; $display("FAIL after_reset_match[%0d] got %b want %b", i, match, e.m); end
            release_all();
        end
        n_cmp++; if (hits != 1) begin n_fail++; $display("FAIL after_reset_hits got %0d want 1", hits); end
    endtask

    task automatic test_ambiguous();
        exp_t       e;
        logic [3:0] f0;
        f0 = fill;
        @(negedge clk);
        btn[0] = 1'b1;
        btn[1] = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        n_cmp++; if (sym_err !== 1'b1) begin n_fail++; $display("FAIL ac_symerr got %b want 1", sym_err); end
        n_cmp++; if (fill !== f0) begin n_fail++; $display("FAIL ac_fill got %0d want %0d", fill, f0); end
        n_cmp++; if (match !== 1'b0) begin n_fail++; $display("FAIL ac_match got %b want 0", match); end
        @(posedge clk);
        #1;
        n_cmp++; if (sym_err !== 1'b0) begin n_fail++; $display("FAIL ac_pulse got %b want 0", sym_err); end
        release_all();
        // New rise on C while A is held: A accepted, C rejected.
        push_press(2'b00);
        e = sb.pop_front();
        n_cmp++; if (fill !== e.f) begin n_fail++; $display("FAIL held_a_fill got %0d want %0d", fill, e.f); end
        @(negedge clk);
        btn[1] = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        n_cmp++; if (sym_err !== 1'b1) begin n_fail++; $display("FAIL held_c_symerr got %b want 1", sym_err); end
        n_cmp++; if (fill !== e.f) begin n_fail++; $display("FAIL held_c_fill got %0d want %0d", fill, e.f); end
        release_all();
    endtask

    task automatic test_hold_one_symbol();
        exp_t e;
        do_reset();
        @(negedge clk);
        btn[2] = 1'b1;
        model_accept(2'b10);
        repeat (LAT + 10) @(posedge clk);
        #1;
        e = sb.pop_front();
        n_cmp++; if (fill !== e.f) begin n_fail++; $display("FAIL hold_fill got %0d want %0d", fill, e.f); end
        release_all();
`ifdef DNA_DEBOUNCE_EN
        // A two-cycle glitch must be filtered out.
        @(negedge clk);
        btn[0] = 1'b1;
        repeat (2) @(negedge clk);
        btn[0] = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        n_cmp++; if (fill !== e.f) begin n_fail++; $display("FAIL glitch_fill got %0d want %0d", fill, e.f); end
`endif
    endtask

    task automatic test_saturate();
        logic [1:0] exp_c[$];
        logic [1:0] want;
        int         c;
        do_reset();
        c = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sat_btn[0] = 1'b1;
            if (i >= 1 && c < 3) c++;
            exp_c.push_back(2'(c));
            repeat (LAT) @(posedge clk);
            #1;
            want = exp_c.pop_front();
            n_cmp++; if (sat_count !== want) begin n_fail++; $display("FAIL sat_count[%0d] got %0d want %0d", i, sat_count, want); end
            @(negedge clk);
            sat_btn = '0;
            repeat (LAT + 2) @(negedge clk);
        end
        n_cmp++; if (sat_super !== 1'b1) begin n_fail++; $display("FAIL sat_super got %b want 1", sat_super); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_reset_hold();
        test_single_match();
        test_overlap_super();
        test_pat_load_and_reset();
        test_ambiguous();
        test_hold_one_symbol();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
